// File: rtl/box_overlay_multi_if.sv
// Pixel stream bundle between the upstream read FIFO, the overlay core and the downstream write FIFO.
// The core uses the master view; the surrounding FIFO logic (or a bench) uses the slave view.
interface box_overlay_multi_if #(
  parameter int PIXEL_W = 24
);
  logic               in_empty;
  logic               in_rd_en;
  logic [PIXEL_W-1:0] in_dout;
  logic               out_full;
  logic               out_wr_en;
  logic [PIXEL_W-1:0] out_din;
  logic               frame_done;

  modport master (
    input  in_empty, in_dout, out_full,
    output in_rd_en, out_wr_en, out_din, frame_done
  );

  modport slave (
    output in_empty, in_dout, out_full,
    input  in_rd_en, out_wr_en, out_din, frame_done
  );
endinterface

// File: rtl/box_overlay_multi.sv
// Streaming RGB overlay: paints up to NUM_BOXES outline/solid rectangles onto a raster pixel stream.
// Box geometry is latched at the first pixel of each frame so mid-frame updates never tear.
module box_overlay_multi #(
  parameter int IMG_WIDTH  = 768,
  parameter int IMG_HEIGHT = 576,
  parameter int NUM_BOXES  = 4,
  parameter int THICKNESS  = 2,
  parameter int COORD_W    = 10,
  parameter int PIXEL_W    = 24
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_BOXES-1:0]         box_en,
  input  logic [NUM_BOXES*COORD_W-1:0] box_x,
  input  logic [NUM_BOXES*COORD_W-1:0] box_y,
  input  logic [NUM_BOXES*COORD_W-1:0] box_w,
  input  logic [NUM_BOXES*COORD_W-1:0] box_h,
  input  logic [NUM_BOXES*PIXEL_W-1:0] box_color,
  input  logic [NUM_BOXES-1:0]         fill_mode,
  box_overlay_multi_if.master          px
);

  localparam int CW1 = COORD_W + 1;
  localparam logic [CW1-1:0]     T_EXT    = CW1'(THICKNESS);
  localparam logic [CW1-1:0]     T2_EXT   = CW1'(2 * THICKNESS);
  localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(IMG_WIDTH - 1);
  localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(IMG_HEIGHT - 1);

  logic [COORD_W-1:0] col_reg, row_reg;
  logic [COORD_W-1:0] col_next, row_next;
  logic               valid_reg, last_reg;
  logic [PIXEL_W-1:0] pix_reg, pix_next;
  logic               pop, first_px, last_px;

  logic [NUM_BOXES-1:0]         en_reg, fill_reg;
  logic [NUM_BOXES*COORD_W-1:0] x_reg, y_reg, w_reg, h_reg;
  logic [NUM_BOXES*PIXEL_W-1:0] color_reg;

  logic [NUM_BOXES-1:0]         en_eff, fill_eff;
  logic [NUM_BOXES*COORD_W-1:0] x_eff, y_eff, w_eff, h_eff;
  logic [NUM_BOXES*PIXEL_W-1:0] color_eff;
  logic [NUM_BOXES-1:0]         hit;
  logic [CW1-1:0]               c_ext, r_ext;

  // Reset gates the pop so nothing is consumed from upstream while the core is held.
  assign pop           = !reset && !px.in_empty && (!valid_reg || !px.out_full);
  assign px.in_rd_en   = pop;
  assign px.out_wr_en  = valid_reg && !px.out_full;
  assign px.out_din    = pix_reg;
  assign px.frame_done = valid_reg && !px.out_full && last_reg;

  assign first_px = (col_reg == '0) && (row_reg == '0);
  assign last_px  = (col_reg == LAST_COL) && (row_reg == LAST_ROW);

  // Pixel (0,0) already sees this frame's geometry, so bypass the shadow on that pop.
  assign en_eff    = first_px ? box_en    : en_reg;
  assign fill_eff  = first_px ? fill_mode : fill_reg;
  assign x_eff     = first_px ? box_x     : x_reg;
  assign y_eff     = first_px ? box_y     : y_reg;
  assign w_eff     = first_px ? box_w     : w_reg;
  assign h_eff     = first_px ? box_h     : h_reg;
  assign color_eff = first_px ? box_color : color_reg;

  assign c_ext = {1'b0, col_reg};
  assign r_ext = {1'b0, row_reg};

  for (genvar gi = 0; gi < NUM_BOXES; gi++) begin : gen_box
    logic [CW1-1:0] bx, by, bw, bh, x_end, y_end;
    logic           in_box, on_edge, thin;

    assign bx    = {1'b0, x_eff[gi*COORD_W +: COORD_W]};
    assign by    = {1'b0, y_eff[gi*COORD_W +: COORD_W]};
    assign bw    = {1'b0, w_eff[gi*COORD_W +: COORD_W]};
    assign bh    = {1'b0, h_eff[gi*COORD_W +: COORD_W]};
    // One extra bit keeps the far edge from wrapping; bw/bh of zero are masked below.
    assign x_end = bx + bw - CW1'(1);
    assign y_end = by + bh - CW1'(1);

    assign in_box = en_eff[gi] && (bw != '0) && (bh != '0) &&
                    (c_ext >= bx) && (c_ext <= x_end) &&
                    (r_ext >= by) && (r_ext <= y_end);
    // When thin, the inner rectangle is empty; x_end-T may underflow but is then unused.
    assign thin    = (bw <= T2_EXT) || (bh <= T2_EXT);
    assign on_edge = (c_ext < bx + T_EXT) || (c_ext > x_end - T_EXT) ||
                     (r_ext < by + T_EXT) || (r_ext > y_end - T_EXT);
    assign hit[gi] = in_box && (fill_eff[gi] || thin || on_edge);
  end

  // Walk from the highest index down so the lowest-index hit wins.
  always_comb begin
    pix_next = px.in_dout;
    for (int i = NUM_BOXES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        pix_next = color_eff[i*PIXEL_W +: PIXEL_W];
      end
    end
  end

  always_comb begin
    col_next = col_reg;
    row_next = row_reg;
    if (col_reg == LAST_COL) begin
      col_next = '0;
      row_next = (row_reg == LAST_ROW) ? '0 : row_reg + COORD_W'(1);
    end else begin
      col_next = col_reg + COORD_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (pop) begin
      col_reg <= col_next;
      row_reg <= row_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
      pix_reg   <= '0;
    end else if (pop) begin
      valid_reg <= 1'b1;
      last_reg  <= last_px;
      pix_reg   <= pix_next;
    end else if (px.out_wr_en) begin
      valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      en_reg    <= '0;
      fill_reg  <= '0;
      x_reg     <= '0;
      y_reg     <= '0;
      w_reg     <= '0;
      h_reg     <= '0;
      color_reg <= '0;
    end else if (pop && first_px) begin
      en_reg    <= box_en;
      fill_reg  <= fill_mode;
      x_reg     <= box_x;
      y_reg     <= box_y;
      w_reg     <= box_w;
      h_reg     <= box_h;
      color_reg <= box_color;
    end
  end

endmodule

// File: tb/tb_box_overlay_multi.sv
// Randomised bench for box_overlay_multi on a reduced 64x48 frame, checked against a rule-level model.
module tb_box_overlay_multi;

  localparam int W    = 64;
  localparam int H    = 48;
  localparam int NB   = 4;
  localparam int T    = 2;
  localparam int CW   = 10;
  localparam int PW   = 24;
  localparam int NPIX = W * H;
  localparam int BUDGET = 20000;

  logic clock;
  logic reset;

  logic          cfg_en[NB];
  logic          cfg_fill[NB];
  logic [CW-1:0] cfg_x[NB], cfg_y[NB], cfg_w[NB], cfg_h[NB];
  logic [PW-1:0] cfg_color[NB];

  logic          sh_en[NB];
  logic          sh_fill[NB];
  logic [CW-1:0] sh_x[NB], sh_y[NB], sh_w[NB], sh_h[NB];
  logic [PW-1:0] sh_color[NB];

  logic [NB-1:0]    box_en, fill_mode;
  logic [NB*CW-1:0] box_x, box_y, box_w, box_h;
  logic [NB*PW-1:0] box_color;

  for (genvar gi = 0; gi < NB; gi++) begin : gen_pack
    assign box_en[gi]                 = cfg_en[gi];
    assign fill_mode[gi]              = cfg_fill[gi];
    assign box_x[gi*CW +: CW]         = cfg_x[gi];
    assign box_y[gi*CW +: CW]         = cfg_y[gi];
    assign box_w[gi*CW +: CW]         = cfg_w[gi];
    assign box_h[gi*CW +: CW]         = cfg_h[gi];
    assign box_color[gi*PW +: PW]     = cfg_color[gi];
  end

  box_overlay_multi_if #(.PIXEL_W(PW)) pix_if ();

  box_overlay_multi #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .NUM_BOXES (NB),
    .THICKNESS (T),
    .COORD_W   (CW),
    .PIXEL_W   (PW)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .box_en   (box_en),
    .box_x    (box_x),
    .box_y    (box_y),
    .box_w    (box_w),
    .box_h    (box_h),
    .box_color(box_color),
    .fill_mode(fill_mode),
    .px       (pix_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [PW-1:0] pix;
    bit            last;
  } exp_t;

  exp_t          exp_q[$];
  logic [PW-1:0] in_img[NPIX];
  logic [PW-1:0] out_img[NPIX];
  logic [PW-1:0] head_pix;
  logic [PW-1:0] prev_din;
  bit            prev_hold;
  int            checks;
  int            errors;
  int            frame_no;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h (frame %0d)", tag, got, exp, frame_no);
    end
  endtask

  // Expected pixel straight from the geometric rules, using the frame's latched config.
  function automatic logic [PW-1:0] model_pix(input int c, input int r, input logic [PW-1:0] pin);
    for (int i = 0; i < NB; i++) begin
      int x, y, w, h;
      bit in_box, hit;
      x = int'(sh_x[i]);
      y = int'(sh_y[i]);
      w = int'(sh_w[i]);
      h = int'(sh_h[i]);
      in_box = sh_en[i] && w != 0 && h != 0 &&
               c >= x && c <= x + w - 1 && r >= y && r <= y + h - 1;
      if (sh_fill[i] || w <= 2 * T || h <= 2 * T)
        hit = in_box;
      else
        hit = in_box && (c < x + T || c > x + w - 1 - T || r < y + T || r > y + h - 1 - T);
      if (hit) return sh_color[i];
    end
    return pin;
  endfunction

  function automatic int idx(input int c, input int r);
    return r * W + c;
  endfunction

  task automatic cfg_clear();
    for (int i = 0; i < NB; i++) begin
      cfg_en[i] = 1'b0; cfg_fill[i] = 1'b0;
      cfg_x[i] = '0; cfg_y[i] = '0; cfg_w[i] = '0; cfg_h[i] = '0;
      cfg_color[i] = '0;
    end
  endtask

  task automatic cfg_random();
    for (int i = 0; i < NB; i++) begin
      cfg_en[i]    = ($urandom_range(0, 3) != 0);
      cfg_fill[i]  = $urandom_range(0, 1) == 1;
      cfg_x[i]     = CW'(($urandom_range(0, 7) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, W + 4));
      cfg_y[i]     = CW'(($urandom_range(0, 7) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, H + 4));
      cfg_w[i]     = CW'(($urandom_range(0, 7) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, W / 2));
      cfg_h[i]     = CW'(($urandom_range(0, 7) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, H / 2));
      cfg_color[i] = PW'($urandom);
    end
  endtask

  task automatic set_box(input int i, input bit fill, input int x, input int y, input int w,
                         input int h, input logic [PW-1:0] color);
    cfg_en[i] = 1'b1; cfg_fill[i] = fill;
    cfg_x[i] = CW'(x); cfg_y[i] = CW'(y); cfg_w[i] = CW'(w); cfg_h[i] = CW'(h);
    cfg_color[i] = color;
  endtask

  // Streams one frame; abort_at>0 stops after that many pops, chg_pop>=0 moves box0 to chg_x then.
  task automatic run_frame(input bit stall, input int abort_at, input int chg_pop, input int chg_x);
    int   pops, pushes, dones, cyc;
    bit   v;
    exp_t e;
    pops = 0; pushes = 0; dones = 0; cyc = 0;
    while (1) begin
      @(negedge clock);
      if (chg_pop >= 0 && pops == chg_pop) cfg_x[0] = CW'(chg_x);
      pix_if.in_empty = (pops >= NPIX) || (stall && $urandom_range(0, 3) == 0);
      pix_if.out_full = stall && ($urandom_range(0, 1) == 1);
      pix_if.in_dout  = head_pix;
      #1;
      v = (exp_q.size() != 0);
      check_eq("rd_en", pix_if.in_rd_en, !pix_if.in_empty && (!v || !pix_if.out_full));
      check_eq("wr_en", pix_if.out_wr_en, v && !pix_if.out_full);
      if (prev_hold) check_eq("hold", pix_if.out_din, prev_din);
      if (pix_if.out_wr_en && v) begin
        check_eq("pix", pix_if.out_din, exp_q[0].pix);
        check_eq("done", pix_if.frame_done, exp_q[0].last);
        if (pix_if.frame_done) dones++;
        out_img[pushes] = pix_if.out_din;
        void'(exp_q.pop_front());
        pushes++;
      end else begin
        check_eq("done_idle", pix_if.frame_done, 1'b0);
      end
      prev_hold = v && pix_if.out_full;
      prev_din  = pix_if.out_din;
      if (pix_if.in_rd_en) begin
        if (pops == 0) begin
          for (int i = 0; i < NB; i++) begin
            sh_en[i] = cfg_en[i]; sh_fill[i] = cfg_fill[i];
            sh_x[i] = cfg_x[i]; sh_y[i] = cfg_y[i]; sh_w[i] = cfg_w[i]; sh_h[i] = cfg_h[i];
            sh_color[i] = cfg_color[i];
          end
        end
        e.pix  = model_pix(pops % W, pops / W, head_pix);
        e.last = (pops == NPIX - 1);
        exp_q.push_back(e);
        if (pops < NPIX) in_img[pops] = head_pix;
        pops++;
        head_pix = PW'($urandom);
      end
      cyc++;
      if (abort_at > 0 && pops == abort_at) break;
      if (pushes == NPIX) break;
      if (cyc > BUDGET) begin
        check_eq("timeout", pushes, NPIX);
        break;
      end
    end
    if (abort_at == 0) begin
      check_eq("done_pulses", dones, 1);
      $display("frame %0d stall %0d pops %0d pushes %0d done_pulses %0d cycles %0d",
               frame_no, stall, pops, pushes, dones, cyc);
    end else begin
      $display("frame %0d aborted after %0d pops, %0d pushes", frame_no, pops, pushes);
    end
    frame_no++;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    pix_if.in_empty = 1'b0;
    pix_if.out_full = 1'b0;
    #1;
    check_eq("rst_rd", pix_if.in_rd_en, 1'b0);
    check_eq("rst_wr", pix_if.out_wr_en, 1'b0);
    check_eq("rst_done", pix_if.frame_done, 1'b0);
    @(negedge clock);
    #1;
    check_eq("rst_rd2", pix_if.in_rd_en, 1'b0);
    check_eq("rst_wr2", pix_if.out_wr_en, 1'b0);
    check_eq("rst_din", pix_if.out_din, 0);
    @(negedge clock);
    pix_if.in_empty = 1'b1;
    reset = 1'b0;
    exp_q.delete();
    prev_hold = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; frame_no = 0;
    prev_hold = 1'b0; prev_din = '0;
    head_pix = PW'($urandom);
    reset = 1'b1;
    pix_if.in_empty = 1'b1;
    pix_if.out_full = 1'b0;
    pix_if.in_dout  = '0;
    cfg_clear();
    do_reset();

    // Overlapping fill and outline boxes: lower index wins.
    set_box(0, 1'b1, 10, 10, 4, 4, 24'hFF0000);
    set_box(1, 1'b0, 12, 12, 8, 8, 24'h00FF00);
    run_frame(1'b0, 0, -1, 0);
    check_eq("ovl_12_12", out_img[idx(12, 12)], 24'hFF0000);
    check_eq("ovl_13_13", out_img[idx(13, 13)], 24'hFF0000);
    check_eq("ovl_15_12", out_img[idx(15, 12)], 24'h00FF00);
    check_eq("ovl_19_19", out_img[idx(19, 19)], 24'h00FF00);
    check_eq("ovl_17_17", out_img[idx(17, 17)], in_img[idx(17, 17)]);
    check_eq("ovl_14_14", out_img[idx(14, 14)], in_img[idx(14, 14)]);

    // Box running off the bottom-right corner is clipped, no wrap.
    cfg_clear();
    set_box(0, 1'b1, 60, 44, 20, 20, 24'h123456);
    run_frame(1'b0, 0, -1, 0);
    check_eq("clip_63_47", out_img[idx(63, 47)], 24'h123456);
    check_eq("clip_60_44", out_img[idx(60, 44)], 24'h123456);
    check_eq("clip_59_47", out_img[idx(59, 47)], in_img[idx(59, 47)]);
    check_eq("clip_0_0",   out_img[idx(0, 0)],   in_img[idx(0, 0)]);
    check_eq("clip_63_0",  out_img[idx(63, 0)],  in_img[idx(63, 0)]);
    check_eq("clip_0_47",  out_img[idx(0, 47)],  in_img[idx(0, 47)]);

    cfg_random();
    run_frame(1'b1, 0, -1, 0);

    // Geometry change mid-frame only lands on the following frame.
    cfg_clear();
    set_box(0, 1'b0, 10, 2, 20, 44, 24'h0000FF);
    run_frame(1'b1, 0, 30 * W, 30);
    check_eq("shd_10_40", out_img[idx(10, 40)], 24'h0000FF);
    check_eq("shd_11_40", out_img[idx(11, 40)], 24'h0000FF);
    check_eq("shd_12_40", out_img[idx(12, 40)], in_img[idx(12, 40)]);
    check_eq("shd_30_40", out_img[idx(30, 40)], in_img[idx(30, 40)]);
    run_frame(1'b0, 0, -1, 0);
    check_eq("nxt_30_40", out_img[idx(30, 40)], 24'h0000FF);
    check_eq("nxt_10_40", out_img[idx(10, 40)], in_img[idx(10, 40)]);

    cfg_random();
    run_frame(1'b1, 0, $urandom_range(1, NPIX - 1), $urandom_range(0, W));

    // Reset part-way through a frame, then a clean frame from (0,0).
    cfg_random();
    run_frame(1'b1, 1000, -1, 0);
    do_reset();
    cfg_random();
    run_frame(1'b1, 0, -1, 0);

    // Disabled or zero-sized boxes leave the stream untouched.
    cfg_clear();
    cfg_w[0] = CW'(10); cfg_h[0] = CW'(10); cfg_color[0] = 24'hABCDEF;
    set_box(1, 1'b1, 5, 5, 0, 10, 24'h111111);
    set_box(2, 1'b0, 5, 5, 10, 0, 24'h222222);
    run_frame(1'b0, 0, -1, 0);
    check_eq("pass_5_5", out_img[idx(5, 5)], in_img[idx(5, 5)]);
    check_eq("pass_0_0", out_img[idx(0, 0)], in_img[idx(0, 0)]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/box_overlay_multi.md
Name: box_overlay_multi

Overview:
Streaming RGB overlay core that draws up to NUM_BOXES rectangles, in outline or solid mode, onto a raster pixel stream.
- Sits between an upstream pixel FIFO (read side) and a downstream FIFO (write side) inside the box-drawing top.
- Generalises the single fixed-colour box to multiple boxes with per-box colour, configurable edge thickness and configurable frame size.
- Box geometry is shadowed per frame, so software may update it mid-frame without tearing.

Parameters:
IMG_WIDTH, 768, pixels per line
IMG_HEIGHT, 576, lines per frame
NUM_BOXES, 4, number of independent boxes
THICKNESS, 2, outline edge thickness in pixels (>=1)
COORD_W, 10, coordinate/size width
PIXEL_W, 24, pixel width ({B,G,R} as streamed)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
box_en  in  NUM_BOXES  per-box enable
box_x  in  NUM_BOXES*COORD_W  left column, box i at [i*COORD_W +: COORD_W]
box_y  in  NUM_BOXES*COORD_W  top row (stream order)
box_w  in  NUM_BOXES*COORD_W  width in pixels
box_h  in  NUM_BOXES*COORD_W  height in pixels
box_color  in  NUM_BOXES*PIXEL_W  draw colour
fill_mode  in  NUM_BOXES  1 = solid fill, 0 = outline
in_empty  in  1  upstream FIFO empty
in_rd_en  out  1  upstream FIFO pop
in_dout  in  PIXEL_W  upstream pixel
out_full  in  1  downstream FIFO full
out_wr_en  out  1  downstream FIFO push
out_din  out  PIXEL_W  output pixel
frame_done  out  1  one-cycle pulse when the last pixel of a frame is pushed

Behaviour:
- Reset (async, active-high): col=0, row=0, pipeline valid=0, out_din=0, out_wr_en=0, in_rd_en=0, frame_done=0, all shadow registers 0 (all boxes disabled).
- Pipeline: a single output register with a valid bit.
  - in_rd_en = !in_empty && (!valid || !out_full), combinational.
  - out_wr_en = valid && !out_full.
  - Latency: pixel popped in cycle N is presented on out_din from cycle N+1.
  - Full throughput: 1 pixel/cycle when upstream is non-empty and downstream is not full.
  - Simultaneous push and pop keeps valid=1 and loads the new pixel.
- Position counters: col/row advance only on in_rd_en.
  - col wraps IMG_WIDTH-1 -> 0 and increments row.
  - row wraps IMG_HEIGHT-1 -> 0.
  - Row 0 is the first line in the stream.
- Shadow load: on the pop of pixel (0,0), box_en/x/y/w/h/color/fill_mode are sampled and used for the whole frame. The pixel (0,0) itself uses the newly sampled values. Input changes at any other time have no effect until the next frame.
- Hit test for box i at (c,r):
  - Inside: en && w!=0 && h!=0 && x<=c<=x+w-1 && y<=r<=y+h-1.
  - Compute in COORD_W+1 bits; no wrap. Boxes extending past the frame are clipped naturally.
  - Outline mode: hit = inside && (c<x+T || c>x+w-1-T || r<y+T || r>y+h-1-T), with T = THICKNESS.
  - If w<=2T or h<=2T the outline box degenerates to solid.
  - Fill mode: hit = inside.
- Priority: the lowest-index hitting box supplies box_color. With no hit, in_dout passes through unchanged.
- frame_done: asserts for exactly one cycle, coincident with the out_wr_en that pushes pixel (IMG_WIDTH-1, IMG_HEIGHT-1).
- Back-pressure: while out_full=1 with valid=1, out_din holds and the counters freeze.
- Reset mid-frame: counters return to (0,0) and any pending pixel is dropped. Upstream must be re-aligned to a frame start.

Test Plan:
- Box0 x=100,y=100,w=50,h=50, outline, T=2, red 0x0000FF, 768x576 gradient input -> pixels (100..149,100),(100..149,101),(100,102..149),(148..149,102..149) etc. become 0x0000FF; (102,102) and (99,100) pass through; exact match against the golden image.
- Box0 fill x=10,y=10,w=4,h=4 blue and box1 outline x=12,y=12,w=8,h=8 green overlapping -> (12,12),(13,13) blue (box0 priority); (15,12) green; (17,17) passes through.
- Box x=760,y=570,w=20,h=20 fill -> columns 760..767, rows 570..575 coloured; no wrap into col 0/row 0; frame_done pulses once, after the 442368th push.
- Random out_full toggling (50%) and random in_empty -> output sequence identical to the no-stall run; no pixel lost or duplicated; out_din stable while out_full=1.
- Change box0 x from 100 to 200 at row 300 -> rest of the current frame still draws at x=100; the next frame draws at x=200.
- Assert reset at pixel 1000 for 2 cycles, then restream a full frame -> out_wr_en=0 and frame_done=0 during reset; the new frame is correct from (0,0); box_en=0 or w=0 yields pure passthrough.
